// File: rtl/div_if.sv
// Request/response bundle for the iterative divider: operands and op code in,
// busy/valid/result out.
interface div_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            flush_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, flush_i,
    input  busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, flush_i,
    output busy_o, valid_o, result_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
//
// state | meaning
// IDLE  | no operation in progress, waiting for start_i
// CALC  | iterating, one quotient bit per edge (count 0..XLEN-1)
// FIX   | sign correction and quotient/remainder selection
module div_unit #(
  parameter int XLEN = 32
) (
  input logic  clk_i,
  input logic  rst_n_i,
  div_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state_q;
  logic            busy_q;
  logic            valid_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] div_q;
  logic [CW-1:0]   cnt_q;
  logic            sel_rem_q;
  logic            neg_q_q;
  logic            neg_r_q;

  logic            signed_op;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            ovf;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_diff;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  always_comb begin
    signed_op = ~bus.op_i[0];
    a_neg     = signed_op & bus.dividend_i[XLEN-1];
    b_neg     = signed_op & bus.divisor_i[XLEN-1];
    abs_a     = a_neg ? (~bus.dividend_i + 1'b1) : bus.dividend_i;
    abs_b     = b_neg ? (~bus.divisor_i + 1'b1) : bus.divisor_i;
    div_zero  = (bus.divisor_i == '0);
    ovf       = signed_op && (bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                && (bus.divisor_i == '1);
    // Extra top bit makes the borrow of the trial subtraction the compare result.
    rem_shift = {rem_q, quo_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, div_q};
    quo_fix   = neg_q_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix   = neg_r_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      sel_rem_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            busy_q    <= 1'b1;
            sel_rem_q <= bus.op_i[1];
            div_q     <= abs_b;
            cnt_q     <= '0;
            // Special cases preload the final answer and skip sign fix-up.
            if (div_zero) begin
              quo_q   <= '1;
              rem_q   <= bus.dividend_i;
              neg_q_q <= 1'b0;
              neg_r_q <= 1'b0;
              state_q <= FIX;
            end else if (ovf) begin
              quo_q   <= bus.dividend_i;
              rem_q   <= '0;
              neg_q_q <= 1'b0;
              neg_r_q <= 1'b0;
              state_q <= FIX;
`ifdef DIV_EARLY_OUT_EN
            end else if (abs_a < abs_b) begin
              quo_q   <= '0;
              rem_q   <= bus.dividend_i;
              neg_q_q <= 1'b0;
              neg_r_q <= 1'b0;
              state_q <= FIX;
`endif
            end else begin
              quo_q   <= abs_a;
              rem_q   <= '0;
              neg_q_q <= a_neg ^ b_neg;
              neg_r_q <= a_neg;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            if (!rem_diff[XLEN]) begin
              rem_q <= rem_diff[XLEN-1:0];
              quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
              rem_q <= rem_shift[XLEN-1:0];
              quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_q <= FIX;
          end
        end
        FIX: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (!bus.flush_i) begin
            result_q <= sel_rem_q ? rem_fix : quo_fix;
            valid_q  <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, sign handling, special cases, flush, reset.
module tb_div_unit;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  div_if #(.XLEN(32)) dif ();

  div_unit #(.XLEN(32)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drives a start from an off-edge point, waits for valid_o (bounded), checks
  // latency, busy duration and result. poke>0 re-asserts start_i while busy.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int poke);
    int lat;
    int busy_cnt;
    bit seen;
    dif.start_i    = 1'b1;
    dif.op_i       = op;
    dif.dividend_i = a;
    dif.divisor_i  = b;
    @(posedge clk); #1;
    dif.start_i = 1'b0;
    chk({tag, "_busy_acc"}, 32'(dif.busy_o), 32'd1);
    chk({tag, "_valid_acc"}, 32'(dif.valid_o), 32'd0);
    lat = 0; busy_cnt = 0; seen = 0;
    while (!seen && lat < 60) begin
      if (poke > 0 && lat == poke) begin
        dif.start_i    = 1'b1;
        dif.dividend_i = 32'd50;
        dif.divisor_i  = 32'd5;
      end
      @(posedge clk); #1;
      dif.start_i = 1'b0;
      lat++;
      if (dif.valid_o) seen = 1;
      else if (dif.busy_o) busy_cnt++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_len"}, 32'(busy_cnt), 32'(exp_lat - 1));
    chk({tag, "_busy_done"}, 32'(dif.busy_o), 32'd0);
    chk({tag, "_res"}, dif.result_o, exp);
  endtask

  initial begin
    int vcount;
    rst_n          = 1'b0;
    dif.start_i    = 1'b0;
    dif.op_i       = 2'b00;
    dif.dividend_i = '0;
    dif.divisor_i  = '0;
    dif.flush_i    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(dif.busy_o), 32'd0);
    chk("rst_valid", 32'(dif.valid_o), 32'd0);
    chk("rst_result", dif.result_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Consecutive calls exercise back-to-back starts on the valid_o cycle.
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
    run_op("div_m20_m3", OP_DIV, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6, 33, 0);
    run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);

    // Flush 10 cycles after accept.
    dif.start_i    = 1'b1;
    dif.op_i       = OP_DIVU;
    dif.dividend_i = 32'd1000;
    dif.divisor_i  = 32'd3;
    @(posedge clk); #1;
    dif.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 dif.flush_i = 1'b1;
    @(posedge clk); #1;
    dif.flush_i = 1'b0;
    chk("flush_busy", 32'(dif.busy_o), 32'd0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (dif.valid_o) vcount++;
    end
    chk("flush_no_valid", 32'(vcount), 32'd0);
    chk("flush_result_kept", dif.result_o, 32'h8000_0000);
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 0);

    // Start ignored while busy: poked operands 50/5 must not disturb 100/7.
    run_op("busy_ignore", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 4);

    // Flush and start together in IDLE: flush wins.
    dif.start_i    = 1'b1;
    dif.flush_i    = 1'b1;
    dif.dividend_i = 32'd8;
    dif.divisor_i  = 32'd2;
    @(posedge clk); #1;
    dif.start_i = 1'b0;
    dif.flush_i = 1'b0;
    chk("idle_flush_busy", 32'(dif.busy_o), 32'd0);
    @(posedge clk); #1;
    chk("idle_flush_valid", 32'(dif.valid_o), 32'd0);

    // Asynchronous reset mid-operation.
    dif.start_i    = 1'b1;
    dif.op_i       = OP_DIVU;
    dif.dividend_i = 32'd100;
    dif.divisor_i  = 32'd7;
    @(posedge clk); #1;
    dif.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(dif.busy_o), 32'd0);
    chk("mid_rst_valid", 32'(dif.valid_o), 32'd0);
    chk("mid_rst_result", dif.result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst_21_4", OP_DIVU, 32'd21, 32'd4, 32'd5, 33, 0);

    run_op("divu_3_10", OP_DIVU, 32'd3, 32'd10, 32'd0, EO_LAT, 0);
    run_op("remu_3_10", OP_REMU, 32'd3, 32'd10, 32'd3, EO_LAT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
